// File: rtl/clk_div_ctrl_pkg.sv
// Shared timebase definitions: FSM state encodings and the default counter width.
package clk_div_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with the clk_out and tick registers; one toggle every div cycles while run is high.
// Output changes one cycle after the terminal count; no backpressure, div must be nonzero.
module clk_div_core
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    output logic             term,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign term = run && (cnt == (div - CNT_W'(1)));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (term) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
        end else begin
            tick <= 1'b0;
            if (run) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: ratio handshake, reload at half-period boundaries, clean start/stop.
// Registered outputs; cfg_ready is low while a reload is pending (accepted, not yet applied).
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = 2500000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_div;
    logic             pend_v;
    logic [CNT_W-1:0] acc_div;
    logic             accept;
    logic             term;

    assign cfg_ready = ~pend_v;
    assign accept    = cfg_valid && cfg_ready;
    assign acc_div   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    assign running   = (state != ST_IDLE);

    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk_in  (clk_in),
        .rst     (rst),
        .run     (running),
        .div     (div_q),
        .term    (term),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stopping only finishes on the falling toggle, so the last high phase is always whole.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_RUN;
            ST_RUN:  if (!en) state_nxt = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (term && clk_out) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // An accept coinciding with a wrap bypasses the pending slot and takes effect at that wrap.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_q    <= CNT_W'(DEF_DIV);
            pend_div <= '0;
            pend_v   <= 1'b0;
        end else begin
            if (accept && !term) begin
                pend_div <= acc_div;
                pend_v   <= 1'b1;
            end
            if (state == ST_IDLE && pend_v) begin
                div_q  <= pend_div;
                pend_v <= 1'b0;
            end
            if (term) begin
                if (pend_v) begin
                    div_q  <= pend_div;
                    pend_v <= 1'b0;
                end else if (accept) begin
                    div_q <= acc_div;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset, start, reload, zero ratio, clean stop, same-cycle bypass.
module tb_clk_div_ctrl;

    logic        clk_in;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_div;
    logic        clk_out;
    logic        tick;
    logic        running;

    int checks = 0;
    int errors = 0;
    int n;

    clk_div_ctrl #(.CNT_W(32), .DEF_DIV(7)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Counts falling edges of clk_in until clk_out reaches lvl; saturates at 100.
    task automatic wait_level(input logic lvl, output int cnt);
        cnt = 0;
        while (clk_out !== lvl && cnt < 100) begin
            @(negedge clk_in);
            cnt++;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        @(negedge clk_in);
        rst = 1'b1;
    endtask

    task automatic load(input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_running", running, 0);
        rst = 1'b1;

        // Reset while high with a reload pending
        en = 1'b1;
        @(negedge clk_in);
        chk("def_running", running, 1);
        wait_level(1'b1, n);
        chk("def_first_rise", n, 7);
        cfg_valid = 1'b1;
        cfg_div   = 32'd2;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("pend_cfg_ready", cfg_ready, 0);
        rst = 1'b0;
        #1;
        chk("arst_clk_out", clk_out, 0);
        chk("arst_running", running, 0);
        chk("arst_cfg_ready", cfg_ready, 1);
        chk("arst_tick", tick, 0);
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        chk("post_rst_running", running, 1);
        wait_level(1'b1, n);
        chk("post_rst_rise_def", n, 7);

        // Load 3 while idle, then run
        do_reset();
        cfg_valid = 1'b1;
        cfg_div   = 32'd3;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("idle_acc_ready_low", cfg_ready, 0);
        @(negedge clk_in);
        chk("idle_apply_ready_high", cfg_ready, 1);
        en = 1'b1;
        @(negedge clk_in);
        chk("div3_running", running, 1);
        chk("div3_start_low", clk_out, 0);
        wait_level(1'b1, n);
        chk("div3_first_rise", n, 3);
        chk("div3_tick_rise", tick, 1);
        wait_level(1'b0, n);
        chk("div3_high", n, 3);
        chk("div3_tick_fall", tick, 1);
        wait_level(1'b1, n);
        chk("div3_low", n, 3);

        // Reload 5 accepted at cnt=1, applied at the cnt=2 wrap
        @(negedge clk_in);
        chk("div3_tick_gap", tick, 0);
        cfg_valid = 1'b1;
        cfg_div   = 32'd5;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("rl_ready_low", cfg_ready, 0);
        @(negedge clk_in);
        chk("rl_ready_back", cfg_ready, 1);
        chk("rl_wrap_low", clk_out, 0);
        wait_level(1'b1, n);
        chk("rl_low5", n, 5);
        wait_level(1'b0, n);
        chk("rl_high5", n, 5);

        // Ratio 0 behaves as 1
        do_reset();
        load(32'd0);
        en = 1'b1;
        @(negedge clk_in);
        chk("div0_start", clk_out, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            chk("div0_toggle", clk_out, (i % 2 == 0) ? 1 : 0);
            chk("div0_tick", tick, 1);
        end

        // Clean stop at div=4, en dropped with clk_out low and cnt=1
        do_reset();
        load(32'd4);
        en = 1'b1;
        @(negedge clk_in);
        wait_level(1'b1, n);
        chk("stop_rise", n, 4);
        wait_level(1'b0, n);
        chk("stop_fall", n, 4);
        @(negedge clk_in);
        en = 1'b0;
        wait_level(1'b1, n);
        chk("stop_low_rest", n, 3);
        chk("stop_running", running, 1);
        wait_level(1'b0, n);
        chk("stop_full_high", n, 4);
        chk("stop_idle", running, 0);
        repeat (6) @(negedge clk_in);
        chk("stop_stays_low", clk_out, 0);
        chk("stop_no_tick", tick, 0);
        chk("stop_stays_idle", running, 0);

        // en returns during STOPPING: no restart, phase continues
        en = 1'b1;
        @(negedge clk_in);
        wait_level(1'b1, n);
        chk("resume_rise", n, 4);
        @(negedge clk_in);
        en = 1'b0;
        @(negedge clk_in);
        chk("resume_stopping", running, 1);
        en = 1'b1;
        wait_level(1'b0, n);
        chk("resume_fall", n, 2);
        wait_level(1'b1, n);
        chk("resume_next_rise", n, 4);
        chk("resume_running", running, 1);

        // Accept coincident with the wrap at div=3
        do_reset();
        load(32'd3);
        en = 1'b1;
        @(negedge clk_in);
        wait_level(1'b1, n);
        chk("byp_rise", n, 3);
        repeat (2) @(negedge clk_in);
        cfg_valid = 1'b1;
        cfg_div   = 32'd2;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("byp_ready_high", cfg_ready, 1);
        chk("byp_wrap_low", clk_out, 0);
        wait_level(1'b1, n);
        chk("byp_low2", n, 2);
        wait_level(1'b0, n);
        chk("byp_high2", n, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
